// File: rtl/h2f_vram_bridge.sv
// Avalon-MM slave that posts HPS writes into a small FIFO and drains them onto the PPU VRAM
// write port while the PPU is idle; also turns the PPU write-window pulse into a maskable IRQ.
module h2f_vram_bridge #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W:0]       avs_address,
  input  logic                  avs_write,
  input  logic [DATA_W-1:0]     avs_writedata,
  input  logic [DATA_W/8-1:0]   avs_byteenable,
  input  logic                  avs_read,
  output logic [DATA_W-1:0]     avs_readdata,
  output logic                  avs_readdatavalid,
  output logic                  avs_waitrequest,
  output logic                  avs_irq,
  output logic [ADDR_W-1:0]     vram_wraddr,
  output logic                  vram_wren,
  output logic [DATA_W-1:0]     vram_wrdata,
  output logic [DATA_W/8-1:0]   vram_byteena,
  input  logic                  cpu_wr_busy,
  input  logic                  vram_wr_irq
);
  localparam int BE_W  = DATA_W / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_W + DATA_W + BE_W;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DRAIN = 2'd1, S_HOLD = 2'd2} state_t;

  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  state_t            r_state, w_state_nxt;
  logic              w_full, w_empty, w_vram_sel, w_push, w_pop;
  logic              w_csr_wr, w_sel_status, w_sel_count, w_irq_edge, w_irq_clr;
  logic              r_irq_d, r_irq_pending, r_irq_enable;
  logic [15:0]       r_wr_count;
  logic [DATA_W-1:0] w_rd_val;
  logic [ENT_W-1:0]  w_head;

  // Waitrequest looks only at the registered fill level, so a pop never races the stall.
  assign w_full          = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_empty         = (r_count == {CNT_W{1'b0}});
  assign w_vram_sel      = !avs_address[ADDR_W];
  assign avs_waitrequest = avs_write & w_vram_sel & w_full;
  assign w_push          = avs_write & w_vram_sel & !w_full & (avs_byteenable != {BE_W{1'b0}});
  assign w_head          = r_mem[r_rptr];

  assign w_csr_wr     = avs_write & avs_address[ADDR_W];
  assign w_sel_status = (avs_address[ADDR_W-1:0] == ADDR_W'(0));
  assign w_sel_count  = (avs_address[ADDR_W-1:0] == ADDR_W'(1));
  assign w_irq_edge   = vram_wr_irq & !r_irq_d;
  assign w_irq_clr    = w_csr_wr & w_sel_status & avs_byteenable[0] & avs_writedata[0];
  assign avs_irq      = r_irq_pending & r_irq_enable;

  always_comb begin
    w_pop       = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_push || !w_empty) begin
          w_state_nxt = cpu_wr_busy ? S_HOLD : S_DRAIN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_DRAIN, S_HOLD: begin
        w_pop = !cpu_wr_busy && !w_empty;
        if (w_pop && !w_push && (r_count == CNT_W'(1))) begin
          w_state_nxt = S_IDLE;
        end else if (cpu_wr_busy) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CNT_W'(1);
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - CNT_W'(1);
    end else begin
      w_count_nxt = r_count;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= {CNT_W{1'b0}};
      r_wptr  <= {PTR_W{1'b0}};
      r_rptr  <= {PTR_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {avs_address[ADDR_W-1:0], avs_writedata, avs_byteenable};
  end

  // Output stage: address/data/byteena hold their last value between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vram_wren    <= 1'b0;
      vram_wraddr  <= {ADDR_W{1'b0}};
      vram_wrdata  <= {DATA_W{1'b0}};
      vram_byteena <= {BE_W{1'b0}};
    end else begin
      vram_wren <= w_pop;
      if (w_pop) {vram_wraddr, vram_wrdata, vram_byteena} <= w_head;
    end
  end

  // A new edge in the same cycle as a W1C keeps the interrupt pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irq_d       <= 1'b0;
      r_irq_pending <= 1'b0;
      r_irq_enable  <= 1'b0;
      r_wr_count    <= 16'd0;
    end else begin
      r_irq_d       <= vram_wr_irq;
      r_irq_pending <= w_irq_edge | (r_irq_pending & !w_irq_clr);
      if (w_csr_wr && w_sel_status && avs_byteenable[1]) r_irq_enable <= avs_writedata[8];
      if (w_csr_wr && w_sel_count) begin
        r_wr_count <= 16'd0;
      end else if (vram_wren) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end

  always_comb begin
    w_rd_val = {DATA_W{1'b0}};
    if (avs_address[ADDR_W] && w_sel_status) begin
      w_rd_val[0] = r_irq_pending;
      w_rd_val[1] = cpu_wr_busy;
      w_rd_val[2] = w_empty;
      w_rd_val[3] = w_full;
      w_rd_val[8] = r_irq_enable;
    end else if (avs_address[ADDR_W] && w_sel_count) begin
      w_rd_val[15:0] = r_wr_count;
    end else begin
      w_rd_val = {DATA_W{1'b0}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      avs_readdatavalid <= 1'b0;
      avs_readdata      <= {DATA_W{1'b0}};
    end else begin
      avs_readdatavalid <= avs_read;
      avs_readdata      <= avs_read ? w_rd_val : {DATA_W{1'b0}};
    end
  end
endmodule

// File: tb/tb_h2f_vram_bridge.sv
// Directed bench for h2f_vram_bridge: inputs change and outputs are sampled 1 ns after posedge.
module tb_h2f_vram_bridge;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 64;
  localparam int BE_W   = 8;
  localparam logic [ADDR_W:0] CSR_STATUS = 14'h2000;
  localparam logic [ADDR_W:0] CSR_COUNT  = 14'h2001;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W:0]   avs_address = '0;
  logic              avs_write = 1'b0;
  logic [DATA_W-1:0] avs_writedata = '0;
  logic [BE_W-1:0]   avs_byteenable = '0;
  logic              avs_read = 1'b0;
  logic [DATA_W-1:0] avs_readdata;
  logic              avs_readdatavalid, avs_waitrequest, avs_irq;
  logic [ADDR_W-1:0] vram_wraddr;
  logic              vram_wren;
  logic [DATA_W-1:0] vram_wrdata;
  logic [BE_W-1:0]   vram_byteena;
  logic              cpu_wr_busy = 1'b0;
  logic              vram_wr_irq = 1'b0;

  int n_pass = 0;
  int n_total = 0;
  int wait_hits = 0;

  h2f_vram_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .avs_address(avs_address), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_byteenable(avs_byteenable), .avs_read(avs_read), .avs_readdata(avs_readdata),
    .avs_readdatavalid(avs_readdatavalid), .avs_waitrequest(avs_waitrequest), .avs_irq(avs_irq),
    .vram_wraddr(vram_wraddr), .vram_wren(vram_wren), .vram_wrdata(vram_wrdata),
    .vram_byteena(vram_byteena), .cpu_wr_busy(cpu_wr_busy), .vram_wr_irq(vram_wr_irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic csr_read(input logic [ADDR_W:0] addr, input logic [63:0] exp, input string tag);
    avs_address = addr;
    avs_read    = 1'b1;
    tick();
    avs_read = 1'b0;
    chk({tag, "_vld"}, {63'd0, avs_readdatavalid}, 64'd1);
    chk(tag, avs_readdata, exp);
  endtask

  task automatic csr_write(input logic [ADDR_W:0] addr, input logic [63:0] data, input logic [7:0] be);
    avs_address    = addr;
    avs_writedata  = data;
    avs_byteenable = be;
    avs_write      = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic vwr(input logic [ADDR_W-1:0] addr, input logic [63:0] data, input logic [7:0] be);
    avs_address    = {1'b0, addr};
    avs_writedata  = data;
    avs_byteenable = be;
    avs_write      = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(); tick(); tick();
    chk("rst_wren", {63'd0, vram_wren}, 64'd0);
    chk("rst_wait", {63'd0, avs_waitrequest}, 64'd0);
    chk("rst_irq", {63'd0, avs_irq}, 64'd0);
    chk("rst_rvalid", {63'd0, avs_readdatavalid}, 64'd0);
    chk("rst_wraddr", {51'd0, vram_wraddr}, 64'd0);
    rst = 1'b0;
    tick();
    csr_read(CSR_STATUS, 64'h4, "rst_status");
    csr_read(CSR_COUNT, 64'h0, "rst_count");

    // T1: single write, two-cycle latency
    vwr(13'h0005, 64'h1122334455667788, 8'hFF);
    chk("t1_not_yet", {63'd0, vram_wren}, 64'd0);
    tick();
    chk("t1_wren", {63'd0, vram_wren}, 64'd1);
    chk("t1_addr", {51'd0, vram_wraddr}, 64'h5);
    chk("t1_data", vram_wrdata, 64'h1122334455667788);
    chk("t1_be", {56'd0, vram_byteena}, 64'hFF);
    tick();
    chk("t1_pulse", {63'd0, vram_wren}, 64'd0);
    chk("t1_hold", {51'd0, vram_wraddr}, 64'h5);
    csr_read(CSR_COUNT, 64'h1, "t1_count");

    // T2: busy fills the FIFO, third write stalls, then ordered drain
    cpu_wr_busy = 1'b1;
    avs_address = {1'b0, 13'h0010}; avs_writedata = 64'hA0; avs_byteenable = 8'hFF; avs_write = 1'b1;
    tick();
    avs_address = {1'b0, 13'h0011}; avs_writedata = 64'hA1;
    tick();
    avs_address = {1'b0, 13'h1FFF}; avs_writedata = 64'hA2;
    #1;
    chk("t2_wait_full", {63'd0, avs_waitrequest}, 64'd1);
    tick();
    chk("t2_wait_hold", {63'd0, avs_waitrequest}, 64'd1);
    chk("t2_busy_nowren", {63'd0, vram_wren}, 64'd0);
    tick();
    chk("t2_busy_nowren2", {63'd0, vram_wren}, 64'd0);
    cpu_wr_busy = 1'b0;
    tick();
    chk("t2_w0", {63'd0, vram_wren}, 64'd1);
    chk("t2_a0", {51'd0, vram_wraddr}, 64'h10);
    chk("t2_d0", vram_wrdata, 64'hA0);
    chk("t2_wait_rel", {63'd0, avs_waitrequest}, 64'd0);
    tick();
    avs_write = 1'b0;
    chk("t2_w1", {63'd0, vram_wren}, 64'd1);
    chk("t2_a1", {51'd0, vram_wraddr}, 64'h11);
    chk("t2_d1", vram_wrdata, 64'hA1);
    tick();
    chk("t2_w2", {63'd0, vram_wren}, 64'd1);
    chk("t2_a2", {51'd0, vram_wraddr}, 64'h1FFF);
    chk("t2_d2", vram_wrdata, 64'hA2);
    tick();
    chk("t2_end", {63'd0, vram_wren}, 64'd0);

    // T3: empty byteenable is dropped, partial byteenable passes through
    vwr(13'h0020, 64'hDEAD, 8'h00);
    tick();
    chk("t3_drop1", {63'd0, vram_wren}, 64'd0);
    tick();
    chk("t3_drop2", {63'd0, vram_wren}, 64'd0);
    csr_read(CSR_COUNT, 64'h4, "t3_count");
    vwr(13'h0021, 64'hAABBCCDD00112233, 8'h0F);
    tick();
    chk("t3_wren", {63'd0, vram_wren}, 64'd1);
    chk("t3_be", {56'd0, vram_byteena}, 64'h0F);
    chk("t3_addr", {51'd0, vram_wraddr}, 64'h21);

    // T4: interrupt set, set-wins-over-clear, clear, mask
    csr_write(CSR_STATUS, 64'h100, 8'h02);
    csr_read(CSR_STATUS, 64'h104, "t4_status_en");
    chk("t4_idle", {63'd0, avs_irq}, 64'd0);
    vram_wr_irq = 1'b1;
    tick();
    chk("t4_set", {63'd0, avs_irq}, 64'd1);
    vram_wr_irq = 1'b0;
    tick();
    chk("t4_sticky", {63'd0, avs_irq}, 64'd1);
    vram_wr_irq = 1'b1;
    csr_write(CSR_STATUS, 64'h1, 8'h01);
    chk("t4_setwins", {63'd0, avs_irq}, 64'd1);
    csr_write(CSR_STATUS, 64'h1, 8'h01);
    chk("t4_clr", {63'd0, avs_irq}, 64'd0);
    csr_write(CSR_STATUS, 64'h0, 8'h02);
    vram_wr_irq = 1'b0;
    tick();
    vram_wr_irq = 1'b1;
    tick();
    chk("t4_mask", {63'd0, avs_irq}, 64'd0);
    csr_read(CSR_STATUS, 64'h5, "t4_status_pend");
    csr_write(CSR_STATUS, 64'h1, 8'h01);
    vram_wr_irq = 1'b0;

    // T5: reset with a full FIFO and a stalled write
    cpu_wr_busy = 1'b1;
    vwr(13'h0030, 64'hB0, 8'hFF);
    vwr(13'h0031, 64'hB1, 8'hFF);
    csr_read(CSR_STATUS, 64'hA, "t5_status_full");
    avs_address = {1'b0, 13'h0032}; avs_writedata = 64'hB2; avs_byteenable = 8'hFF; avs_write = 1'b1;
    #1;
    chk("t5_wait_pre", {63'd0, avs_waitrequest}, 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_wait_rst", {63'd0, avs_waitrequest}, 64'd0);
    chk("t5_wren_rst", {63'd0, vram_wren}, 64'd0);
    avs_write = 1'b0;
    cpu_wr_busy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("t5_stale0", {63'd0, vram_wren}, 64'd0);
    tick();
    chk("t5_stale1", {63'd0, vram_wren}, 64'd0);
    tick();
    chk("t5_stale2", {63'd0, vram_wren}, 64'd0);
    csr_read(CSR_STATUS, 64'h4, "t5_status");
    csr_read(CSR_COUNT, 64'h0, "t5_count");

    // T6: 0xFFFF streamed writes, then wrap to zero
    avs_byteenable = 8'hFF;
    avs_write = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      avs_address   = {1'b0, i[12:0]};
      avs_writedata = 64'(i);
      tick();
      if (avs_waitrequest) wait_hits++;
    end
    avs_write = 1'b0;
    chk("t6_nostall", 64'(wait_hits), 64'd0);
    tick(); tick(); tick();
    csr_read(CSR_COUNT, 64'hFFFF, "t6_ffff");
    vwr(13'h0040, 64'hC0, 8'hFF);
    tick(); tick(); tick();
    avs_address = CSR_COUNT;
    avs_read    = 1'b1;
    #1;
    chk("t6_lat0", {63'd0, avs_readdatavalid}, 64'd0);
    tick();
    avs_read = 1'b0;
    chk("t6_lat1", {63'd0, avs_readdatavalid}, 64'd1);
    chk("t6_wrap", avs_readdata, 64'h0);
    tick();
    chk("t6_lat2", {63'd0, avs_readdatavalid}, 64'd0);
    chk("t6_rdzero", avs_readdata, 64'h0);
    vwr(13'h0041, 64'hC1, 8'hFF);
    tick(); tick(); tick();
    csr_read(CSR_COUNT, 64'h1, "t6_one");
    csr_write(CSR_COUNT, 64'h0, 8'hFF);
    csr_read(CSR_COUNT, 64'h0, "t6_clear");
    csr_read({1'b0, 13'h0041}, 64'h0, "t6_vram_rd");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
